// File: rtl/div_arbiter_if.sv
// Engine-side bus of the divider arbiter: start/ready/done handshake plus operands and results.
// The arbiter owns the master modport; the divider controller/datapath owns the slave modport.
// Operands are held by the master from GRANT through WAIT; results are valid only with eng_done.
interface div_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             eng_ready;
  logic             eng_start;
  logic [WIDTH-1:0] eng_dvd;
  logic [WIDTH-1:0] eng_dvs;
  logic             eng_done;
  logic [WIDTH-1:0] eng_quo;
  logic [WIDTH-1:0] eng_rem;

  modport master (
    input  eng_ready, eng_done, eng_quo, eng_rem,
    output eng_start, eng_dvd, eng_dvs
  );

  modport slave (
    output eng_ready, eng_done, eng_quo, eng_rem,
    input  eng_start, eng_dvd, eng_dvs
  );
endinterface

// File: rtl/div_arbiter.sv
// Shares one sequential divider between two clients, round-robin on ties, with a done watchdog.
// Latency: req cycle 0, arbitrate 1, GRANT 2, START 3, WAIT from 4, done the cycle after eng_done.
// Backpressure: one pending request per client (busyN); GRANT stalls until eng_ready is high.
module div_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dvd0,
  input  logic [WIDTH-1:0] dvs0,
  input  logic [WIDTH-1:0] dvd1,
  input  logic [WIDTH-1:0] dvs1,
  output logic             busy0,
  output logic             busy1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  div_arbiter_if.master    eng
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             pending0;
  logic             pending1;
  logic [WIDTH-1:0] hdvd0;
  logic [WIDTH-1:0] hdvs0;
  logic [WIDTH-1:0] hdvd1;
  logic [WIDTH-1:0] hdvs1;

  logic             sel;
  logic             last;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;

  logic             pick_vld;
  logic             pick;
  logic             tie;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             timeout_hit;
  logic             dvs_zero;
  logic             start_c;

  // The watchdog fires in the WAIT cycle whose increment brings the counter to TIMEOUT-1.
  assign cnt_inc     = cnt + CW'(1);
  assign timeout_hit = (cnt_inc == CNT_LAST);
  assign dvs_zero    = (dvs_r == '0);

  assign busy0         = pending0;
  assign busy1         = pending1;
  assign eng.eng_start = start_c;
  assign eng.eng_dvd   = dvd_r;
  assign eng.eng_dvs   = dvs_r;

  // Client 0 holding register: accept only while idle-for-this-client, release on its response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending0 <= 1'b0;
      hdvd0    <= '0;
      hdvs0    <= '0;
    end else if (req0 && !pending0) begin
      pending0 <= 1'b1;
      hdvd0    <= dvd0;
      hdvs0    <= dvs0;
    end else if (state == RESP && !sel) begin
      pending0 <= 1'b0;
    end
  end

  // Client 1 holding register: same policy as client 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending1 <= 1'b0;
      hdvd1    <= '0;
      hdvs1    <= '0;
    end else if (req1 && !pending1) begin
      pending1 <= 1'b1;
      hdvd1    <= dvd1;
      hdvs1    <= dvs1;
    end else if (state == RESP && sel) begin
      pending1 <= 1'b0;
    end
  end

  // Arbitration: a lone pending client wins; on a tie the client other than last wins.
  always_comb begin
    pick_vld = pending0 | pending1;
    tie      = pending0 & pending1;
    pick     = tie ? ~last : pending1;
  end

  // Grant registers: selection, tie history and the operands presented to the engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel   <= 1'b0;
      last  <= 1'b1;
      dvd_r <= '0;
      dvs_r <= '0;
    end else if (state == IDLE && pick_vld) begin
      sel   <= pick;
      dvd_r <= pick ? hdvd1 : hdvd0;
      dvs_r <= pick ? hdvs1 : hdvs0;
      if (tie) begin
        last <= pick;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT:   if (dvs_zero) state_nxt = RESP;
               else if (eng.eng_ready) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (eng.eng_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so they drop with an async reset.
  always_comb begin
    start_c = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    case (state)
      START:   start_c = 1'b1;
      RESP: begin
        done0 = ~sel;
        done1 = sel;
      end
      default: start_c = 1'b0;
    endcase
  end

  // Watchdog counter: cleared on start, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt_inc;
    end
  end

  // Result registers: engine result, or error with zeroed result; eng_done beats the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
      quo <= '0;
      rem <= '0;
    end else if (state == GRANT && dvs_zero) begin
      err <= 1'b1;
      quo <= '0;
      rem <= '0;
    end else if (state == WAIT && eng.eng_done) begin
      err <= 1'b0;
      quo <= eng.eng_quo;
      rem <= eng.eng_rem;
    end else if (state == WAIT && timeout_hit) begin
      err <= 1'b1;
      quo <= '0;
      rem <= '0;
    end
  end

endmodule
